// File: rtl/clock_set_ctrl.sv
// Run/set controller for the 24-hour seven-segment clock.
// Debounced buttons step RUN/SET_H/SET_M/SET_S and edit one field at a time.
module clock_set_ctrl #(
   parameter int CLK_HZ       = 100_000_000,
   parameter int DEBOUNCE_CYC = 2_000_000,
   parameter int BLINK_HALF   = 25_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        btn_mode,
   input  logic        btn_inc,
   input  logic        btn_dec,
   output logic [4:0]  hh,
   output logic [5:0]  mm,
   output logic [5:0]  ss,
   output logic [16:0] seconds,
   output logic [1:0]  mode,
   output logic        tick_1hz,
   output logic [5:0]  blink_mask
);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      SET_H = 2'd1,
      SET_M = 2'd2,
      SET_S = 2'd3
   } mode_t;

   localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam int DW = $clog2(DEBOUNCE_CYC + 1);
   localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);
   localparam logic [DW-1:0] DB_MAX  = DW'(DEBOUNCE_CYC - 1);
   localparam logic [BW-1:0] BL_MAX  = BW'(BLINK_HALF - 1);

   // Button index: 0 mode, 1 inc, 2 dec
   logic [2:0]    w_raw;
   logic [2:0]    r_sync1, r_sync2, r_lvl, r_lvl_d, r_pulse;
   logic [DW-1:0] r_db_cnt [3];

   mode_t         r_mode, w_mode_nxt;
   logic [PW-1:0] r_pre;
   logic          r_tick;
   logic [4:0]    r_hh;
   logic [5:0]    r_mm, r_ss;
   logic [BW-1:0] r_bcnt;
   logic          r_phase;
   logic [5:0]    r_mask, w_mask_nxt;
   logic          w_mode_p, w_inc, w_dec, w_wrap;

   assign w_raw = {btn_dec, btn_inc, btn_mode};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_lvl   <= '0;
         r_lvl_d <= '0;
         r_pulse <= '0;
         for (int b = 0; b < 3; b++) r_db_cnt[b] <= '0;
      end else begin
         r_sync1 <= w_raw;
         r_sync2 <= r_sync1;
         r_lvl_d <= r_lvl;
         r_pulse <= r_lvl & ~r_lvl_d;
         for (int b = 0; b < 3; b++) begin
            if (r_sync2[b] == r_lvl[b]) begin
               r_db_cnt[b] <= '0;
            end else if (r_db_cnt[b] == DB_MAX) begin
               r_lvl[b]    <= r_sync2[b];
               r_db_cnt[b] <= '0;
            end else begin
               r_db_cnt[b] <= r_db_cnt[b] + 1'b1;
            end
         end
      end
   end

   // A mode press masks any edit in the same cycle
   assign w_mode_p = r_pulse[0];
   assign w_inc    = r_pulse[1] & ~r_pulse[2] & ~w_mode_p;
   assign w_dec    = r_pulse[2] & ~r_pulse[1] & ~w_mode_p;
   assign w_wrap   = (r_mode == RUN) && (r_pre == PRE_MAX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_mode <= RUN;
      else     r_mode <= w_mode_nxt;
   end

   always_comb begin
      w_mode_nxt = r_mode;
      if (w_mode_p) begin
         unique case (r_mode)
            RUN:   w_mode_nxt = SET_H;
            SET_H: w_mode_nxt = SET_M;
            SET_M: w_mode_nxt = SET_S;
            SET_S: w_mode_nxt = RUN;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pre  <= '0;
         r_tick <= 1'b0;
         r_hh   <= '0;
         r_mm   <= '0;
         r_ss   <= '0;
      end else begin
         r_tick <= 1'b0;
         if (r_mode == RUN) begin
            if (w_wrap) begin
               r_pre  <= '0;
               r_tick <= 1'b1;
               if (r_ss == 6'd59) begin
                  r_ss <= '0;
                  if (r_mm == 6'd59) begin
                     r_mm <= '0;
                     r_hh <= (r_hh == 5'd23) ? '0 : r_hh + 1'b1;
                  end else begin
                     r_mm <= r_mm + 1'b1;
                  end
               end else begin
                  r_ss <= r_ss + 1'b1;
               end
            end else begin
               r_pre <= r_pre + 1'b1;
            end
            if (w_mode_p) r_pre <= '0;
         end else begin
            r_pre <= '0;
            case (r_mode)
               SET_H: begin
                  if (w_inc)      r_hh <= (r_hh == 5'd23) ? '0 : r_hh + 1'b1;
                  else if (w_dec) r_hh <= (r_hh == 5'd0) ? 5'd23 : r_hh - 1'b1;
               end
               SET_M: begin
                  if (w_inc)      r_mm <= (r_mm == 6'd59) ? '0 : r_mm + 1'b1;
                  else if (w_dec) r_mm <= (r_mm == 6'd0) ? 6'd59 : r_mm - 1'b1;
               end
               SET_S: begin
                  if (w_inc)      r_ss <= (r_ss == 6'd59) ? '0 : r_ss + 1'b1;
                  else if (w_dec) r_ss <= (r_ss == 6'd0) ? 6'd59 : r_ss - 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      w_mask_nxt = 6'b000000;
      if (r_phase) begin
         case (r_mode)
            SET_H:   w_mask_nxt = 6'b110000;
            SET_M:   w_mask_nxt = 6'b001100;
            SET_S:   w_mask_nxt = 6'b000011;
            default: w_mask_nxt = 6'b000000;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bcnt  <= '0;
         r_phase <= 1'b0;
         r_mask  <= '0;
      end else begin
         if (r_bcnt == BL_MAX) begin
            r_bcnt  <= '0;
            r_phase <= ~r_phase;
         end else begin
            r_bcnt <= r_bcnt + 1'b1;
         end
         r_mask <= w_mask_nxt;
      end
   end

   assign seconds    = {12'd0, r_hh} * 17'd3600
                     + {11'd0, r_mm} * 17'd60
                     + {11'd0, r_ss};
   assign hh         = r_hh;
   assign mm         = r_mm;
   assign ss         = r_ss;
   assign mode       = r_mode;
   assign tick_1hz   = r_tick;
   assign blink_mask = r_mask;

endmodule
